// File: rtl/slot_alloc_bitmap_pkg.sv
// Shared slot-tracking definitions for dispatch, issue and the slot allocator.
// Holds the default slot geometry and the index-width helper.
package slot_alloc_bitmap_pkg;

    localparam int DEFAULT_DEPTH      = 16;
    localparam int DEFAULT_FREE_PORTS = 2;

    function automatic int idx_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    localparam int DEFAULT_IW = idx_w(DEFAULT_DEPTH);

    typedef logic [DEFAULT_IW-1:0] slot_idx_t;

endpackage

// File: rtl/slot_alloc_bitmap_onehot_decoder.sv
// Index plus enable to one-hot slot mask.
// Out-of-range indices decode to an all-zero mask.
module onehot_decoder #(
    parameter int DEPTH = 16,
    parameter int IW    = 4
) (
    input  logic             i_en,
    input  logic [IW-1:0]    i_idx,
    output logic [DEPTH-1:0] o_mask
);

    always_comb begin
        o_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_mask[i] = i_en && (i_idx == IW'(i));
        end
    end

endmodule

// File: rtl/slot_alloc_bitmap.sv
// Busy/free bitmap for shared queue slots: lowest-free grant,
// multi-port release, flush, and illegal-release reporting.
module slot_alloc_bitmap
    import slot_alloc_bitmap_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int FREE_PORTS = DEFAULT_FREE_PORTS,
    localparam int IW        = idx_w(DEPTH),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alloc_req,
    output logic                     alloc_gnt,
    output logic [IW-1:0]            alloc_idx,
    input  logic [FREE_PORTS-1:0]    free_valid,
    input  logic [FREE_PORTS*IW-1:0] free_idx,
    input  logic                     flush,
    output logic [DEPTH-1:0]         busy_vec,
    output logic [CW-1:0]            count,
    output logic                     full,
    output logic                     empty,
    output logic                     free_err
);

    logic [DEPTH-1:0] r_busy;
    logic [CW-1:0]    r_count;
    logic             r_err;

    logic [DEPTH-1:0] w_masks [FREE_PORTS];
    logic [DEPTH-1:0] w_req_mask;
    logic [DEPTH-1:0] w_clr;
    logic [DEPTH-1:0] w_set;
    logic [IW-1:0]    w_low;
    logic [CW-1:0]    w_pop;
    logic [CW-1:0]    w_next_count;
    logic             w_err;

    for (genvar g = 0; g < FREE_PORTS; g++) begin : g_dec
        onehot_decoder #(
            .DEPTH (DEPTH),
            .IW    (IW)
        ) u_dec (
            .i_en   (free_valid[g]),
            .i_idx  (free_idx[g*IW +: IW]),
            .o_mask (w_masks[g])
        );
    end

    // Descending scan so the last hit is the lowest free slot.
    always_comb begin
        w_low = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_low = IW'(i);
            end
        end
    end

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign alloc_gnt = alloc_req & ~full & ~flush;
    assign alloc_idx = alloc_gnt ? w_low : '0;
    assign w_set     = alloc_gnt ? (DEPTH'(1) << w_low) : '0;

    always_comb begin
        w_req_mask = '0;
        w_err      = 1'b0;
        for (int p = 0; p < FREE_PORTS; p++) begin
            w_req_mask = w_req_mask | w_masks[p];
            if (free_valid[p] && int'(free_idx[p*IW +: IW]) >= DEPTH) begin
                w_err = 1'b1;
            end
            for (int q = 0; q < p; q++) begin
                if (free_valid[p] && free_valid[q] &&
                    free_idx[p*IW +: IW] == free_idx[q*IW +: IW]) begin
                    w_err = 1'b1;
                end
            end
        end
        if (|(w_req_mask & ~r_busy)) begin
            w_err = 1'b1;
        end
    end

    assign w_clr = w_req_mask & r_busy;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_pop = w_pop + CW'(w_clr[i]);
        end
    end

    // Set and clear masks are disjoint, so this never wraps.
    assign w_next_count = r_count + CW'(alloc_gnt) - w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (flush) begin
            r_busy  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_busy  <= (r_busy & ~w_clr) | w_set;
            r_count <= w_next_count;
            r_err   <= w_err;
        end
    end

    assign busy_vec = r_busy;
    assign count    = r_count;
    assign free_err = r_err;

endmodule

// File: tb/tb_slot_alloc_bitmap.sv
// Scoreboard bench for slot_alloc_bitmap: directed scenarios then random
// traffic, checked against an array-based slot model.
module tb_slot_alloc_bitmap;

    localparam int D = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_req;
    logic        alloc_gnt;
    logic [3:0]  alloc_idx;
    logic [1:0]  free_valid;
    logic [7:0]  free_idx;
    logic        flush;
    logic [15:0] busy_vec;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        free_err;

    slot_alloc_bitmap dut (
        .clk        (clk),
        .reset      (reset),
        .alloc_req  (alloc_req),
        .alloc_gnt  (alloc_gnt),
        .alloc_idx  (alloc_idx),
        .free_valid (free_valid),
        .free_idx   (free_idx),
        .flush      (flush),
        .busy_vec   (busy_vec),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .free_err   (free_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string   tag;
        bit      gnt;
        int      idx;
        int      busy;
        int      cnt;
        bit      full;
        bit      empty;
        bit      err;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    bit m_busy [D];
    bit m_err;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, " alloc_gnt"}, int'(alloc_gnt), int'(e.gnt));
                chk({e.tag, " alloc_idx"}, int'(alloc_idx), e.idx);
                chk({e.tag, " busy_vec"},  int'(busy_vec),  e.busy);
                chk({e.tag, " count"},     int'(count),     e.cnt);
                chk({e.tag, " full"},      int'(full),      int'(e.full));
                chk({e.tag, " empty"},     int'(empty),     int'(e.empty));
                chk({e.tag, " free_err"},  int'(free_err),  int'(e.err));
            end
        end
    end

    function automatic exp_t snap(input string tag, input bit gnt,
                                  input int idx);
        exp_t e;
        int   n = 0;
        int   b = 0;
        for (int i = 0; i < D; i++) begin
            if (m_busy[i]) begin
                n++;
                b = b | (1 << i);
            end
        end
        e.tag   = tag;
        e.gnt   = gnt;
        e.idx   = idx;
        e.busy  = b;
        e.cnt   = n;
        e.full  = (n == D);
        e.empty = (n == 0);
        e.err   = m_err;
        return e;
    endfunction

    task automatic step(input string tag, input bit req, input bit [1:0] fv,
                        input int f0, input int f1, input bit fl);
        int  n = 0;
        int  low = -1;
        bit  gnt;
        bit  err = 0;
        bit  clr [D];
        int  fi [2];
        @(posedge clk);
        #1;
        alloc_req  = req;
        free_valid = fv;
        free_idx   = {4'(f1), 4'(f0)};
        flush      = fl;
        for (int i = 0; i < D; i++) begin
            if (m_busy[i]) n++;
            else if (low < 0) low = i;
            clr[i] = 0;
        end
        gnt = req && (n < D) && !fl;
        q.push_back(snap(tag, gnt, gnt ? low : 0));
        if (fl) begin
            for (int i = 0; i < D; i++) m_busy[i] = 0;
            m_err = 0;
        end else begin
            fi[0] = f0;
            fi[1] = f1;
            for (int p = 0; p < 2; p++) begin
                if (fv[p]) begin
                    if (fi[p] >= D)             err = 1;
                    else if (clr[fi[p]])        err = 1;
                    else if (!m_busy[fi[p]])    err = 1;
                    else                        clr[fi[p]] = 1;
                end
            end
            for (int i = 0; i < D; i++) if (clr[i]) m_busy[i] = 0;
            if (gnt) m_busy[low] = 1;
            m_err = err;
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 2'b00, 0, 0, 0);
    endtask

    initial begin
        reset      = 1'b1;
        alloc_req  = 1'b0;
        free_valid = 2'b00;
        free_idx   = '0;
        flush      = 1'b0;
        for (int i = 0; i < D; i++) m_busy[i] = 0;
        m_err = 0;
        repeat (2) @(posedge clk);
        // Reset values while reset is still asserted.
        @(posedge clk);
        #1;
        q.push_back(snap("in_reset", 0, 0));
        @(negedge clk);
        #1;
        reset = 1'b0;

        idle("post_reset");
        for (int i = 0; i < 17; i++) step("fill", 1, 2'b00, 0, 0, 0);
        idle("full");
        step("free5", 0, 2'b01, 5, 0, 0);
        step("realloc5", 1, 2'b00, 0, 0, 0);
        idle("after5");

        step("flush_a", 0, 2'b00, 0, 0, 1);
        for (int i = 0; i < 4; i++) step("fill4", 1, 2'b00, 0, 0, 0);
        step("free13_alloc", 1, 2'b11, 1, 3, 0);
        idle("mask15");

        step("dup_free2", 0, 2'b11, 2, 2, 0);
        idle("dup_err");
        step("free_idle7", 0, 2'b01, 7, 0, 0);
        idle("idle7_err");
        idle("err_clear");

        step("flush_b", 0, 2'b00, 0, 0, 1);
        for (int i = 0; i < 10; i++) step("fill10", 1, 2'b00, 0, 0, 0);
        step("flush_all", 1, 2'b11, 0, 1, 1);
        idle("after_flush");

        for (int i = 0; i < 6; i++) step("fill6", 1, 2'b00, 0, 0, 0);
        idle("six_busy");
        @(posedge clk);
        #2;
        alloc_req  = 1'b0;
        free_valid = 2'b00;
        flush      = 1'b0;
        reset      = 1'b1;
        for (int i = 0; i < D; i++) m_busy[i] = 0;
        m_err = 0;
        q.push_back(snap("async_reset", 0, 0));
        @(negedge clk);
        #1;
        reset = 1'b0;
        step("first_after_reset", 1, 2'b00, 0, 0, 0);
        idle("after_reset_idle");

        for (int k = 0; k < 400; k++) begin
            step("rand",
                 $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, D - 1)),
                 int'($urandom_range(0, D - 1)),
                 $urandom_range(0, 39) == 0);
        end
        idle("drain");
        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/slot_alloc_bitmap.md
# slot_alloc_bitmap

Tracks busy/free state of DEPTH entries for a shared structure such as reservation-station or load/store-queue slots. Each cycle it grants the lowest-numbered free slot to one allocation request. It decodes up to FREE_PORTS released slot indices back into bitmap clears. It sits between dispatch, which allocates, and issue/commit, which frees, and is the index-to-bitmap counterpart of the lowest-index-first priority encoder used in dispatch.

## Interface
- DEPTH, 16, number of tracked slots; must be at least 2.
- FREE_PORTS, 2, number of independent release ports.
- IW, $clog2(DEPTH), slot index width (derived; not overridden).
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- alloc_req  input  1  dispatch requests one slot this cycle.
- alloc_gnt  output  1  a slot is granted this cycle; alloc_req & !full & !flush.
- alloc_idx  output  IW  granted slot index, the lowest free index; 0 when alloc_gnt=0.
- free_valid  input  FREE_PORTS  per-port release strobe.
- free_idx  input  FREE_PORTS x IW  per-port released slot index.
- flush  input  1  frees every slot on the next edge.
- busy_vec  output  DEPTH  registered busy bitmap; bit i=1 means slot i is allocated.
- count  output  $clog2(DEPTH+1)  registered number of busy slots.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- free_err  output  1  registered one-cycle pulse flagging an illegal release.

## Operation
- Grant:
  - alloc_idx is the lowest i with busy_vec[i]==0, taken from the current registered bitmap.
  - On alloc_gnt=1, busy_vec[alloc_idx] is set at the next edge.
- Release:
  - Each valid port is decoded to a one-hot mask.
  - All valid masks are ORed, then ANDed with busy_vec, and the result is cleared at the next edge.
- Illegal release raises free_err on the next cycle and leaves no effect beyond the legal part. Two cases:
  - A port frees an index whose busy bit is already 0.
  - Two ports name the same index in one cycle. That index is cleared once and counted once.
  - Indices ≥DEPTH, possible only when DEPTH is not a power of 2, are illegal, ignored and flagged.
- Alloc and free collision is impossible by construction: grants come only from free bits, and legal frees only touch busy bits. The next-state bitmap is (busy_vec & ~clr_mask) | set_mask.
- A slot freed in cycle N is not grantable until cycle N+1.
- count_next = count + alloc_gnt − popcount(clr_mask). This is exact and never wraps. count must always equal popcount(busy_vec).
- Flush:
  - Takes priority over alloc and free.
  - alloc_gnt is forced to 0 during flush.
  - Next state: busy_vec=0, count=0.
  - free_err is not raised for frees presented during flush.

## Timing
- Reset values: busy_vec=0, count=0, empty=1, full=0, free_err=0. alloc_gnt=0 unless alloc_req is high; alloc_idx=0 after reset.
- Grant is zero-latency: alloc_gnt and alloc_idx are combinational from alloc_req, flush and registered state, with no combinational path from free_*.
- full, empty and count are registered-derived and update one cycle after the triggering alloc, free or flush.
- When full=1 and a free arrives in cycle N, alloc_gnt can go high in cycle N+1.
- Reset asserted mid-operation clears state immediately, independent of clk. Outputs hold reset values until the first edge after deassertion.

## Structure
- Shared package holds:
  - the derived IW function/constant;
  - the slot_idx_t typedef;
  - the default DEPTH and FREE_PORTS constants used by dispatch and issue.
- Sub-module onehot_decoder (IW-bit index plus enable → DEPTH-bit one-hot mask), instantiated once per free port.
- Lowest-free search and popcount are inline loops in this block.

## Test plan
- Reset, then assert alloc_req for 16 cycles (DEPTH=16) → alloc_idx counts 0..15, full=1 one cycle after the 16th grant; a 17th alloc_req gives alloc_gnt=0.
- From full, free slot 5 → next cycle count=15, and alloc_req yields alloc_idx=5.
- Slots 0–3 busy, ports free 1 and 3 in the same cycle as alloc_req → grant idx 4; next cycle busy_vec=0x0015, count=3.
- Both ports free index 2 (busy) → slot 2 cleared once, count decrements by 1, free_err=1 for one cycle; then free idx 7 while slot 7 is idle → free_err=1, busy_vec unchanged.
- 10 slots busy, flush with alloc_req=1 and free_valid=2'b11 → alloc_gnt=0, next cycle busy_vec=0, count=0, empty=1, free_err=0.
- Assert reset asynchronously between edges with 6 slots busy → busy_vec=0 and empty=1 immediately; first alloc after deassertion grants idx 0.
